// File: rtl/regfile_controller.sv
// regfile_controller: instruction decoder/FSM for a register-file datapath; define ILLEGAL_TRAP_EN to trap undefined instructions in HALT.
module regfile_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);
    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_CMP, S_WRITE_REG, S_HALT
    } state_t;
`ifdef ILLEGAL_TRAP_EN
    localparam state_t UNDEF_NEXT = S_HALT;
`else
    localparam state_t UNDEF_NEXT = S_WAIT;
`endif
    state_t state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic is_mov_imm, is_mov_reg, is_mvn, is_add_and, is_cmp;
    assign opcode = ir_q[15:13];
    assign op = ir_q[12:11];
    assign rn = ir_q[10:8];
    assign rd = ir_q[7:5];
    assign rm = ir_q[2:0];
    assign is_mov_imm = opcode == 3'b110 && op == 2'b10;
    assign is_mov_reg = opcode == 3'b110 && op == 2'b00;
    assign is_mvn = opcode == 3'b101 && op == 2'b11;
    assign is_add_and = opcode == 3'b101 && (op == 2'b00 || op == 2'b10);
    assign is_cmp = opcode == 3'b101 && op == 2'b01;
    always_comb begin
        ir_d = (state_q == S_WAIT && load) ? in : ir_q;
        state_d = state_q;
        case (state_q)
            S_WAIT:      state_d = s ? S_DECODE : S_WAIT;
            S_DECODE:    state_d = is_mov_imm ? S_WRITE_IMM :
                                   (is_mov_reg || is_mvn) ? S_GET_B :
                                   (is_add_and || is_cmp) ? S_GET_A : UNDEF_NEXT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = is_cmp ? S_CMP : S_ALU;
            S_ALU:       state_d = S_WRITE_REG;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_WAIT;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
        end
    end
    assign w = state_q == S_WAIT;
    assign illegal = state_q == S_HALT;
    assign write = state_q == S_WRITE_IMM || state_q == S_WRITE_REG;
    assign writenum = state_q == S_WRITE_IMM ? rn : state_q == S_WRITE_REG ? rd : 3'd0;
    assign vsel = state_q == S_WRITE_IMM ? 2'b01 : 2'b00;
    assign readnum = state_q == S_GET_A ? rn : state_q == S_GET_B ? rm : 3'd0;
    assign loada = state_q == S_GET_A;
    assign loadb = state_q == S_GET_B;
    assign loadc = state_q == S_ALU;
    assign asel = state_q == S_ALU && is_mov_reg;
    assign loads = state_q == S_CMP;
    assign bsel = 1'b0;
    assign ALUop = opcode == 3'b101 ? op : 2'b00;
    assign shift = ir_q[4:3];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
endmodule

// File: tb/tb_regfile_controller.sv
// tb_regfile_controller: random and directed instruction runs checked against an instruction-level step model.
module tb_regfile_controller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] in = 16'h0;
    logic load = 1'b0;
    logic s = 1'b0;
    logic w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0] readnum, writenum;
    logic [1:0] vsel, ALUop, shift;
    logic [15:0] sximm8;
    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] ir_m = 16'h0;
    bit halted = 0;
    logic [31:0] exp_q[$];

    regfile_controller dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s),
        .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .vsel(vsel), .ALUop(ALUop), .shift(shift), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {15'd0, w, write, writenum, readnum, vsel, loada, loadb, loadc, loads, asel, bsel, illegal};
    endfunction

    function automatic logic [31:0] e(input logic ew, input logic wr, input logic [2:0] wn, input logic [2:0] rn,
                                      input logic [1:0] vs, input logic la, input logic lb, input logic lc,
                                      input logic ls, input logic as, input logic il);
        return {15'd0, ew, wr, wn, rn, vs, la, lb, lc, ls, as, 1'b0, il};
    endfunction

    function automatic void build(input logic [15:0] ir);
        int opc, op, r_n, r_d, r_m;
        opc = int'(ir[15:13]);
        op = int'(ir[12:11]);
        r_n = int'(ir[10:8]);
        r_d = int'(ir[7:5]);
        r_m = int'(ir[2:0]);
        exp_q = {};
        exp_q.push_back(e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (opc == 6 && op == 2) begin
            exp_q.push_back(e(0, 1, 3'(r_n), 0, 2'b01, 0, 0, 0, 0, 0, 0));
        end else if ((opc == 6 && op == 0) || (opc == 5 && op == 3)) begin
            exp_q.push_back(e(0, 0, 0, 3'(r_m), 0, 0, 1, 0, 0, 0, 0));
            exp_q.push_back(e(0, 0, 0, 0, 0, 0, 0, 1, 0, opc == 6, 0));
            exp_q.push_back(e(0, 1, 3'(r_d), 0, 0, 0, 0, 0, 0, 0, 0));
        end else if (opc == 5) begin
            exp_q.push_back(e(0, 0, 0, 3'(r_n), 0, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(e(0, 0, 0, 3'(r_m), 0, 0, 1, 0, 0, 0, 0));
            if (op == 1) exp_q.push_back(e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            else begin
                exp_q.push_back(e(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
                exp_q.push_back(e(0, 1, 3'(r_d), 0, 0, 0, 0, 0, 0, 0, 0));
            end
        end else begin
`ifdef ILLEGAL_TRAP_EN
            for (int k = 0; k < 4; k++) exp_q.push_back(e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            halted = 1;
`endif
        end
        if (!halted) exp_q.push_back(e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    task automatic apply_reset();
        #2 reset_n = 1'b0;
        s = 1'b1;
        load = 1'b1;
        in = 16'($urandom);
        #1;
        chk("rst_async", obs(), e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_sximm8", 32'(sximm8), 32'h0);
        chk("rst_aluop_shift", {28'd0, ALUop, shift}, 32'h0);
        @(negedge clk);
        chk("rst_hold", obs(), e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_ir", 32'(sximm8), 32'h0);
        s = 1'b0;
        load = 1'b0;
        reset_n = 1'b1;
        ir_m = 16'h0;
        halted = 0;
    endtask

    task automatic run_instr(input logic [15:0] instr, input logic do_load, input string tag);
        logic [15:0] sx;
        if (do_load) begin
            in = instr;
            load = 1'b1;
            ir_m = instr;
            @(negedge clk);
            load = 1'b0;
            in = 16'($urandom);
        end
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        build(ir_m);
        sx = 16'($signed(ir_m[7:0]));
        chk({tag, ":sximm8"}, 32'(sximm8), 32'(sx));
        chk({tag, ":aluop"}, 32'(ALUop), ir_m[15:13] == 3'b101 ? 32'(ir_m[12:11]) : 32'd0);
        chk({tag, ":shift"}, 32'(shift), 32'(ir_m[4:3]));
        foreach (exp_q[i]) begin
            chk($sformatf("%s:step%0d", tag, i), obs(), exp_q[i]);
            if (i < exp_q.size() - 1) begin
                load = 1'($urandom_range(0, 1));
                in = 16'($urandom);
                s = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        load = 1'b0;
        s = 1'b0;
        if (halted) apply_reset();
    endtask

    initial begin
        logic [31:0] rnd;
        logic [4:0] hdr;
        @(negedge clk);
        apply_reset();
        run_instr(16'hD207, 1, "mov_r2_7");
        run_instr(16'hD1FD, 1, "mov_r1_m3");
        run_instr(16'hA162, 1, "add_r3");
        run_instr(16'hA902, 1, "cmp_r1_r2");
        run_instr(16'hC045, 1, "mov_reg");
        run_instr(16'hB8E9, 1, "mvn");
        run_instr(16'hB3A4, 1, "and");
        in = 16'hA162;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort:getb", obs(), e(0, 0, 0, 3'd2, 0, 0, 1, 0, 0, 0, 0));
        apply_reset();
        run_instr(16'h0000, 0, "post_rst_ir0");
        run_instr(16'hE000, 1, "op111");
        for (int n = 0; n < 60; n++) begin
            rnd = $urandom;
            case ($urandom_range(0, 7))
                0: hdr = 5'b11010;
                1: hdr = 5'b11000;
                2: hdr = 5'b10111;
                3: hdr = 5'b10100;
                4: hdr = 5'b10110;
                5: hdr = 5'b10101;
                default: hdr = rnd[31:27];
            endcase
            run_instr({hdr, rnd[10:0]}, 1, $sformatf("rnd%0d", n));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
